// File: rtl/signal_pkg.sv
// Shared definitions for the traffic signal sequencer.
//   state_e   : FSM state codes (also exported on state_o for debug)
//   Lamp*     : one-hot lamp encodings {R,Y,G}
//   max_u     : elaboration-time helper used to size the tick counter
package signal_pkg;

  typedef enum logic [2:0] {
    StAllRedM = 3'd0,
    StMainG   = 3'd1,
    StMainY   = 3'd2,
    StAllRedS = 3'd3,
    StSideG   = 3'd4,
    StSideY   = 3'd5
  } state_e;

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_PER_TICK clocks.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   tick : high for one cycle; first pulse lands CLK_PER_TICK edges after reset release
module tick_gen #(
  parameter int unsigned CLK_PER_TICK = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_TICK - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational decode so the FSM acts on the edge that completes the period.
  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/signal_sequencer.sv
// Two-street traffic signal sequencer with side-street sensor and pedestrian walk.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   s        : side-street vehicle sensor (asynchronous)
//   walk_req : pedestrian button (asynchronous, level or pulse)
//   main_lt  : main-street lamps {R,Y,G}, registered one-hot
//   side_lt  : side-street lamps {R,Y,G}, registered one-hot
//   walk     : pedestrian walk lamp, registered
//   state_o  : current FSM state code
module signal_sequencer
  import signal_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 50000000,
  parameter int unsigned T_MAIN_MIN   = 10,
  parameter int unsigned T_SIDE       = 6,
  parameter int unsigned T_YEL        = 3,
  parameter int unsigned T_ALLRED     = 1,
  parameter int unsigned T_WALK       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s,
  input  logic       walk_req,
  output logic [2:0] main_lt,
  output logic [2:0] side_lt,
  output logic       walk,
  output logic [2:0] state_o
);

  localparam int unsigned TMax =
      max_u(max_u(max_u(T_MAIN_MIN, T_SIDE), max_u(T_YEL, T_ALLRED)), T_WALK);
  localparam int unsigned TcntW = (TMax > 1) ? $clog2(TMax + 1) : 1;

  localparam logic [TcntW-1:0] MainMinLast = TcntW'(T_MAIN_MIN - 1);
  localparam logic [TcntW-1:0] SideLast    = TcntW'(T_SIDE - 1);
  localparam logic [TcntW-1:0] YelLast     = TcntW'(T_YEL - 1);
  localparam logic [TcntW-1:0] AllRedLast  = TcntW'(T_ALLRED - 1);
  localparam logic [TcntW-1:0] WalkTicks   = TcntW'(T_WALK);

  logic tick;

  tick_gen #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Input synchronizers.
  logic s_meta_q, s_sync_q, walk_meta_q, walk_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta_q    <= 1'b0;
      s_sync_q    <= 1'b0;
      walk_meta_q <= 1'b0;
      walk_sync_q <= 1'b0;
    end else begin
      s_meta_q    <= s;
      s_sync_q    <= s_meta_q;
      walk_meta_q <= walk_req;
      walk_sync_q <= walk_meta_q;
    end
  end

  state_e           state_q, state_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             req_side_q, req_side_d;
  logic             req_walk_q, req_walk_d;
  logic             walk_cap_q, walk_cap_d;
  logic [2:0]       main_d, side_d;
  logic             walk_d;
  logic             enter_side;

  // State register and registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAllRedM;
      tcnt_q     <= '0;
      req_side_q <= 1'b0;
      req_walk_q <= 1'b0;
      walk_cap_q <= 1'b0;
      main_lt    <= LampRed;
      side_lt    <= LampRed;
      walk       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      req_side_q <= req_side_d;
      req_walk_q <= req_walk_d;
      walk_cap_q <= walk_cap_d;
      main_lt    <= main_d;
      side_lt    <= side_d;
      walk       <= walk_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StAllRedM: if (tick && tcnt_q == AllRedLast) state_d = StMainG;
      StMainG: begin
        if (tick && tcnt_q >= MainMinLast && (req_side_q || req_walk_q)) state_d = StMainY;
      end
      StMainY:   if (tick && tcnt_q == YelLast)    state_d = StAllRedS;
      StAllRedS: if (tick && tcnt_q == AllRedLast) state_d = StSideG;
      StSideG:   if (tick && tcnt_q == SideLast)   state_d = StSideY;
      StSideY:   if (tick && tcnt_q == YelLast)    state_d = StAllRedM;
      default:   state_d = StAllRedM;
    endcase
  end

  // Tick counter and request latches.
  always_comb begin
    enter_side = (state_d == StSideG) && (state_q != StSideG);

    tcnt_d = tcnt_q;
    if (state_d != state_q) begin
      tcnt_d = '0;
    end else if (tick) begin
      // MAIN_G parks at its minimum so the exit fires on the first tick with a request.
      if (!(state_q == StMainG && tcnt_q >= MainMinLast)) tcnt_d = tcnt_q + 1'b1;
    end

    // Clear on SIDE_G entry takes priority over a coincident set.
    req_side_d = req_side_q;
    req_walk_d = req_walk_q;
    if (enter_side) begin
      req_side_d = 1'b0;
      req_walk_d = 1'b0;
    end else if (state_q != StSideG) begin
      if (s_sync_q)    req_side_d = 1'b1;
      if (walk_sync_q) req_walk_d = 1'b1;
    end

    walk_cap_d = enter_side ? req_walk_q : walk_cap_q;
  end

  // Output decode from the next state so lamps change on the same edge as state.
  always_comb begin
    main_d = LampRed;
    side_d = LampRed;
    walk_d = 1'b0;
    case (state_d)
      StMainG: main_d = LampGrn;
      StMainY: main_d = LampYel;
      StSideG: begin
        side_d = LampGrn;
        walk_d = walk_cap_d && (tcnt_d < WalkTicks);
      end
      StSideY: side_d = LampYel;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_signal_sequencer.sv
module tb_signal_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       s;
  logic       walk_req;
  logic [2:0] main_lt, side_lt, state_o;
  logic       walk;

  signal_sequencer #(
    .CLK_PER_TICK(4),
    .T_MAIN_MIN  (3),
    .T_SIDE      (3),
    .T_YEL       (2),
    .T_ALLRED    (1),
    .T_WALK      (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s       (s),
    .walk_req(walk_req),
    .main_lt (main_lt),
    .side_lt (side_lt),
    .walk    (walk),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  // Edges since reset release; an output change seen at a negedge happened on edge cyc.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         c;
    logic [2:0] st;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       wk;
  } ev_t;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  task automatic push_ev(input int c, input logic [2:0] st, input logic [2:0] ml,
                         input logic [2:0] sl, input logic wk);
    ev_t e;
    e.c  = c;
    e.st = st;
    e.ml = ml;
    e.sl = sl;
    e.wk = wk;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc != n) @(negedge clk);
  endtask

  // Monitor: every change of the observable tuple must match the next queued event.
  logic [9:0] cur, prev, want;
  bit         have_prev = 1'b0;
  ev_t        got_e;

  always @(negedge clk) begin
    cur = {state_o, main_lt, side_lt, walk};
    if ((main_lt != R && side_lt != R) || !$onehot(main_lt) || !$onehot(side_lt)) begin
      miscompares++;
      $display("FAIL lamp_safety cyc=%0d main_lt=%b side_lt=%b", cyc, main_lt, side_lt);
    end
    if (have_prev && cur != prev) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change cyc=%0d st=%0d main=%b side=%b walk=%b",
                 cyc, state_o, main_lt, side_lt, walk);
      end else begin
        got_e = exp_q.pop_front();
        want  = {got_e.st, got_e.ml, got_e.sl, got_e.wk};
        if (cur != want || cyc != got_e.c) begin
          miscompares++;
          $display("FAIL event got cyc=%0d st/main/side/walk=%0d/%b/%b/%b want cyc=%0d %0d/%b/%b/%b",
                   cyc, state_o, main_lt, side_lt, walk,
                   got_e.c, got_e.st, got_e.ml, got_e.sl, got_e.wk);
        end
      end
    end
    prev      = cur;
    have_prev = 1'b1;
  end

  task automatic check_reset_vals(input string name);
    vectors++;
    if (main_lt != R || side_lt != R || walk != 1'b0 || state_o != 3'd0) begin
      miscompares++;
      $display("FAIL %s got st=%0d main=%b side=%b walk=%b want st=0 main=100 side=100 walk=0",
               name, state_o, main_lt, side_lt, walk);
    end
  endtask

  initial begin
    rst      = 1'b1;
    s        = 1'b0;
    walk_req = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_vals("reset_state");

    // Release: ALLRED_M for one tick (4 clks), then MAIN_G.
    push_ev(4, 3'd1, G, R, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Side sensor pulse at MAIN_G tick 1.
    wait_cyc(8);
    push_ev(16, 3'd2, Y, R, 1'b0);
    push_ev(24, 3'd3, R, R, 1'b0);
    s = 1'b1;
    wait_cyc(11);
    s = 1'b0;

    // Walk request during MAIN_Y: walk lit for 2 ticks of SIDE_G.
    wait_cyc(17);
    push_ev(28, 3'd4, R, G, 1'b1);
    push_ev(36, 3'd4, R, G, 1'b0);
    push_ev(40, 3'd5, R, Y, 1'b0);
    push_ev(48, 3'd0, R, R, 1'b0);
    push_ev(52, 3'd1, G, R, 1'b0);
    walk_req = 1'b1;
    wait_cyc(19);
    walk_req = 1'b0;

    // Sensor held through SIDE_G must not re-arm a request; MAIN_G then holds.
    wait_cyc(28);
    s = 1'b1;
    wait_cyc(37);
    s = 1'b0;

    // Second side request, no walk; reset lands mid-cycle in SIDE_G.
    wait_cyc(100);
    push_ev(104, 3'd2, Y, R, 1'b0);
    push_ev(112, 3'd3, R, R, 1'b0);
    push_ev(116, 3'd4, R, G, 1'b0);
    s = 1'b1;
    wait_cyc(103);
    s = 1'b0;

    wait_cyc(118);
    push_ev(0, 3'd0, R, R, 1'b0);
    #1 rst = 1'b1;
    #1 check_reset_vals("async_reset");

    repeat (2) @(negedge clk);
    push_ev(4, 3'd1, G, R, 1'b0);
    rst = 1'b0;
    wait_cyc(40);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events got %0d outstanding want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/signal_sequencer.md
SIGNAL_SEQUENCER -- requirements
Module: signal_sequencer

Interface
REQ-001 Parameter CLK_PER_TICK, default 50000000: clock cycles per timing tick (1 s at 50 MHz).
REQ-002 Parameter T_MAIN_MIN, default 10: minimum main-street green, in ticks.
REQ-003 Parameter T_SIDE, default 6: side-street green, in ticks.
REQ-004 Parameter T_YEL, default 3: yellow duration, in ticks.
REQ-005 Parameter T_ALLRED, default 1: all-red clearance, in ticks.
REQ-006 Parameter T_WALK, default 4: walk duration in ticks; SHALL satisfy T_WALK <= T_SIDE.
REQ-007 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-high.
REQ-009 s  input  1  side-street vehicle sensor, asynchronous to clk.
REQ-010 walk_req  input  1  pedestrian button, asynchronous, level or pulse.
REQ-011 main_lt  output  3  main-street lamps {R,Y,G}, one-hot.
REQ-012 side_lt  output  3  side-street lamps {R,Y,G}, one-hot.
REQ-013 walk  output  1  pedestrian walk lamp for crossing main street.
REQ-014 state_o  output  3  current FSM state code, for debug.

Function
REQ-015 s and walk_req SHALL each pass through a 2-flop synchronizer before use.
REQ-016 tick SHALL be a 1-cycle pulse every CLK_PER_TICK clocks, free-running from reset release.
REQ-017 The FSM SHALL have the states ALLRED_M=0, MAIN_G=1, MAIN_Y=2, ALLRED_S=3, SIDE_G=4, SIDE_Y=5.
REQ-018 The tick counter tcnt SHALL increment on each tick and clear to 0 on every state transition.
REQ-019 Timed exits SHALL occur on the clk edge where tick=1 and tcnt equals the state duration minus 1.
REQ-020 Transitions: ALLRED_M -> MAIN_G after T_ALLRED; MAIN_Y -> ALLRED_S after T_YEL; ALLRED_S -> SIDE_G after T_ALLRED; SIDE_G -> SIDE_Y after T_SIDE; SIDE_Y -> ALLRED_M after T_YEL.
REQ-021 MAIN_G SHALL exit to MAIN_Y only on a tick where tcnt >= T_MAIN_MIN-1 and (req_side or req_walk) is set.
REQ-022 Otherwise MAIN_G SHALL hold, with tcnt saturating at T_MAIN_MIN-1.
REQ-023 req_side SHALL be set by synchronized s high in any state other than SIDE_G, and cleared on entry to SIDE_G.
REQ-024 req_walk SHALL follow the same rule, driven by synchronized walk_req.
REQ-025 A set and a clear of a request latch in the same cycle SHALL resolve as clear.
REQ-026 In SIDE_G, walk SHALL be 1 while tcnt < T_WALK and the walk latch captured at SIDE_G entry is set; walk SHALL be 0 in every other state.
REQ-027 Lamp outputs SHALL be registered Moore outputs that update on the same edge as state.
REQ-028 Lamp values by state: main G only in MAIN_G; main Y only in MAIN_Y; main R in all other states. Side lamps follow the same rule for SIDE_G and SIDE_Y.
REQ-029 Both streets SHALL never show non-red in the same cycle; an illegal state code SHALL recover to ALLRED_M on the next edge.

Reset
REQ-030 While rst=1: state=ALLRED_M, tcnt=0, prescaler=0, request latches=0, synchronizers=0, main_lt=side_lt=3'b100, walk=0, state_o=0.
REQ-031 Reset asserted mid-cycle SHALL force the REQ-030 values immediately, without waiting for a clk edge.
REQ-032 The first tick after reset release SHALL occur CLK_PER_TICK cycles later.

Structure
REQ-033 State codes and lamp encodings (RED=3'b100, YEL=3'b010, GRN=3'b001) SHALL reside in shared package signal_pkg.
REQ-034 The prescaler SHALL be a sub-module named tick_gen, with ports clk, rst and tick.

Verification (CLK_PER_TICK=4, T_MAIN_MIN=3, T_SIDE=3, T_YEL=2, T_ALLRED=1, T_WALK=2)
REQ-035 Reset release, no requests -> ALLRED_M for 4 clks; then MAIN_G with main_lt=001, held indefinitely.
REQ-036 s pulsed for 3 clks at tick 1 of MAIN_G -> MAIN_Y at tick 3, ALLRED_S at tick 5, SIDE_G at tick 6 (side_lt=001) for 3 ticks, SIDE_Y for 2 ticks, then ALLRED_M.
REQ-037 walk_req asserted in MAIN_Y -> walk=1 for the first 8 clks of SIDE_G, then 0.
REQ-038 s held high throughout SIDE_G -> no new request is latched; with s released at SIDE_Y, MAIN_G lasts indefinitely afterwards.
REQ-039 rst asserted during SIDE_G -> lamps read 100/100 within the same cycle; after release, the sequence restarts per REQ-035.
REQ-040 A bench assertion over all runs -> never main_lt!=100 and side_lt!=100 in the same cycle; lamps always one-hot.
